// File: rtl/sigmadelta_mc.sv
// Multi-channel sigma-delta audio DAC: one first- or second-order modulator per
// channel, all sharing a mute/unmute ramp FSM so channels fade in and out together.
module sigmadelta_mc #(
   parameter int CHANNELS   = 2,
   parameter int AUDIO_BITS = 10,
   parameter int ORDER      = 1,
   parameter int SIGNED_IN  = 1,
   parameter int RAMP_SHIFT = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [CHANNELS*AUDIO_BITS-1:0] d,
   input  logic                           d_valid,
   input  logic                           mute,
   output logic [CHANNELS-1:0]            q,
   output logic                           muted,
   output logic                           ramping,
   output logic [1:0]                     fsm_state
);
   localparam int B = AUDIO_BITS;
   localparam logic [B-1:0] MID = {1'b1, {(B-1){1'b0}}};

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      PLAY      = 2'd2,
      RAMP_DOWN = 2'd3
   } state_t;

   state_t              state, state_next;
   logic                tick;
   logic [CHANNELS-1:0] eq_s, eq_m;

   // d_valid is a bare strobe with no ready: every asserted edge latches all
   // channels, and repeated strobes simply overwrite (last value wins).

   if (RAMP_SHIFT == 0) begin : g_tick_every
      assign tick = 1'b1;
   end else begin : g_tick_div
      logic [RAMP_SHIFT-1:0] cnt;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) cnt <= '0;
         else          cnt <= cnt + 1'b1;
      end
      assign tick = &cnt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= MUTED;
      else          state <= state_next;
   end

   // Mute reversals take effect immediately; only the x steps wait for tick.
   always_comb begin
      state_next = state;
      case (state)
         MUTED:     if (!mute) state_next = RAMP_UP;
         RAMP_UP:   if (mute) state_next = RAMP_DOWN;
                    else if (&eq_s) state_next = PLAY;
         PLAY:      if (mute) state_next = RAMP_DOWN;
         RAMP_DOWN: if (!mute) state_next = RAMP_UP;
                    else if (&eq_m) state_next = MUTED;
         default:   state_next = MUTED;
      endcase
   end

   assign muted     = (state == MUTED);
   assign ramping   = (state == RAMP_UP) || (state == RAMP_DOWN);
   assign fsm_state = state;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [B-1:0] u, s, x;
      logic         q_r;

      if (SIGNED_IN != 0) begin : g_signed
         assign u = {~d[c*B+B-1], d[c*B +: B-1]};
      end else begin : g_unsigned
         assign u = d[c*B +: B];
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)     s <= MID;
         else if (d_valid) s <= u;
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            x <= MID;
         end else begin
            case (state)
               MUTED:     x <= MID;
               RAMP_UP:   if (tick && !eq_s[c]) x <= (x < s) ? x + 1'b1 : x - 1'b1;
               PLAY:      x <= s;
               RAMP_DOWN: if (tick && !eq_m[c]) x <= (x < MID) ? x + 1'b1 : x - 1'b1;
               default:   x <= MID;
            endcase
         end
      end

      assign eq_s[c] = (x == s);
      assign eq_m[c] = (x == MID);

      if (ORDER == 1) begin : g_o1
         // The carry out of the B-bit accumulator is the output bit, so acc keeps B bits.
         logic [B-1:0] acc;
         logic [B:0]   sum;
         assign sum = {1'b0, acc} + {1'b0, x};
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               acc <= '0;
               q_r <= 1'b0;
            end else begin
               acc <= sum[B-1:0];
               q_r <= sum[B];
            end
         end
      end else if (ORDER == 2) begin : g_o2
         localparam int W = B + 4;
         logic signed [W-1:0] i1, i2, i1_next, i2_next, xe, fb;
         assign xe      = $signed({4'b0000, x});
         assign fb      = q_r ? $signed({4'b0001, {B{1'b0}}}) : '0;
         assign i1_next = i1 + xe - fb;
         assign i2_next = i2 + i1_next - fb;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               i1  <= '0;
               i2  <= '0;
               q_r <= 1'b0;
            end else begin
               i1  <= i1_next;
               i2  <= i2_next;
               q_r <= ~i2_next[W-1];
            end
         end
      end else begin : g_bad_order
         $error("sigmadelta_mc: ORDER must be 1 or 2");
      end

      assign q[c] = q_r;
   end

endmodule

// File: tb/tb_sigmadelta_mc.sv
// Directed bench for sigmadelta_mc: three instances (1st-order unsigned, 1st-order
// signed with slow ramp, 2nd-order unsigned) share the same stimulus.
module tb_sigmadelta_mc;
   localparam logic [1:0] ST_MUTED = 2'd0;
   localparam logic [1:0] ST_UP    = 2'd1;
   localparam logic [1:0] ST_PLAY  = 2'd2;
   localparam logic [1:0] ST_DOWN  = 2'd3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [19:0] d = '0;
   logic        d_valid = 1'b0;
   logic        mute = 1'b1;

   logic [1:0] u1_q, s1_q, o2_q;
   logic       u1_muted, s1_muted, o2_muted;
   logic       u1_ramping, s1_ramping, o2_ramping;
   logic [1:0] u1_st, s1_st, o2_st;

   int total = 0;
   int bad = 0;
   int cu[2], cs[2], co[2];

   always #5 clk = ~clk;

   sigmadelta_mc #(.CHANNELS(2), .AUDIO_BITS(10), .ORDER(1), .SIGNED_IN(0), .RAMP_SHIFT(0)) u1 (
      .clk(clk), .reset_n(reset_n), .d(d), .d_valid(d_valid), .mute(mute),
      .q(u1_q), .muted(u1_muted), .ramping(u1_ramping), .fsm_state(u1_st));
   sigmadelta_mc #(.CHANNELS(2), .AUDIO_BITS(10), .ORDER(1), .SIGNED_IN(1), .RAMP_SHIFT(2)) s1 (
      .clk(clk), .reset_n(reset_n), .d(d), .d_valid(d_valid), .mute(mute),
      .q(s1_q), .muted(s1_muted), .ramping(s1_ramping), .fsm_state(s1_st));
   sigmadelta_mc #(.CHANNELS(2), .AUDIO_BITS(10), .ORDER(2), .SIGNED_IN(0), .RAMP_SHIFT(0)) o2 (
      .clk(clk), .reset_n(reset_n), .d(d), .d_valid(d_valid), .mute(mute),
      .q(o2_q), .muted(o2_muted), .ramping(o2_ramping), .fsm_state(o2_st));

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic count_ones(input int n);
      for (int c = 0; c < 2; c++) begin
         cu[c] = 0; cs[c] = 0; co[c] = 0;
      end
      repeat (n) begin
         @(negedge clk);
         for (int c = 0; c < 2; c++) begin
            cu[c] += int'(u1_q[c]);
            cs[c] += int'(s1_q[c]);
            co[c] += int'(o2_q[c]);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; mute = 1'b1; d_valid = 1'b0;
      repeat (3) @(negedge clk);
      total++; if ({u1_q, s1_q, o2_q} !== 6'b0) begin bad++; $display("FAIL reset_q: got %b want 000000", {u1_q, s1_q, o2_q}); end
      total++; if ({u1_muted, s1_muted, o2_muted} !== 3'b111) begin bad++; $display("FAIL reset_muted: got %b want 111", {u1_muted, s1_muted, o2_muted}); end
      total++; if ({u1_ramping, s1_ramping, o2_ramping} !== 3'b000) begin bad++; $display("FAIL reset_ramping: got %b want 000", {u1_ramping, s1_ramping, o2_ramping}); end
      total++; if (u1_st !== ST_MUTED) begin bad++; $display("FAIL reset_state: got %0d want %0d", u1_st, ST_MUTED); end
      total++; if (u1.g_ch[0].x !== 10'd512 || u1.g_ch[1].s !== 10'd512) begin bad++; $display("FAIL reset_x_s: got x=%0d s=%0d want 512", u1.g_ch[0].x, u1.g_ch[1].s); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (u1_st !== ST_MUTED || u1_muted !== 1'b1) begin bad++; $display("FAIL hold_muted: got state=%0d want %0d", u1_st, ST_MUTED); end
   endtask

   task automatic test_ramp_up();
      int n_u, n_s;
      bit shape_ok;
      n_u = 0; n_s = 0; shape_ok = 1'b1;
      d = {10'h3FF, 10'h100}; d_valid = 1'b1; mute = 1'b0;
      @(negedge clk);
      d_valid = 1'b0;
      total++; if (u1_st !== ST_UP || u1_ramping !== 1'b1 || u1_muted !== 1'b0) begin bad++; $display("FAIL unmute_first_edge: got state=%0d want %0d", u1_st, ST_UP); end
      total++; if (s1_st !== ST_UP) begin bad++; $display("FAIL unmute_signed: got state=%0d want %0d", s1_st, ST_UP); end
      total++; if (u1.g_ch[0].x !== 10'd512) begin bad++; $display("FAIL unmute_x_start: got %0d want 512", u1.g_ch[0].x); end
      for (int n = 1; n <= 1500 && (n_u == 0 || n_s == 0); n++) begin
         @(negedge clk);
         if (u1.g_ch[1].x !== 10'((n < 511) ? 512 + n : 1023)) shape_ok = 1'b0;
         if (u1.g_ch[0].x !== 10'((n < 256) ? 512 - n : 256)) shape_ok = 1'b0;
         if (n_u == 0 && u1_st == ST_PLAY) n_u = n;
         if (n_s == 0 && s1_st == ST_PLAY) n_s = n;
      end
      total++; if (!shape_ok) begin bad++; $display("FAIL ramp_up_shape: got 0 want 1"); end
      total++; if (n_u != 512) begin bad++; $display("FAIL ramp_up_len: got %0d want 512", n_u); end
      total++; if (n_s < 1022 || n_s > 1025) begin bad++; $display("FAIL ramp_up_tick_len: got %0d want 1022..1025", n_s); end
   endtask

   task automatic test_density_o1();
      repeat (3) @(negedge clk);
      count_ones(1024);
      total++; if (cu[0] != 256) begin bad++; $display("FAIL dens_u_256: got %0d want 256", cu[0]); end
      total++; if (cu[1] != 1023) begin bad++; $display("FAIL dens_u_1023: got %0d want 1023", cu[1]); end
      total++; if (cs[0] != 768) begin bad++; $display("FAIL dens_s_100: got %0d want 768", cs[0]); end
      total++; if (cs[1] != 511) begin bad++; $display("FAIL dens_s_3ff: got %0d want 511", cs[1]); end
   endtask

   task automatic test_signed_latency();
      d = {10'h200, 10'h000}; d_valid = 1'b1;
      @(posedge clk); #1;
      total++; if (u1.g_ch[0].s !== 10'd0 || u1.g_ch[0].x !== 10'd256) begin bad++; $display("FAIL latency_k: got s=%0d x=%0d want s=0 x=256", u1.g_ch[0].s, u1.g_ch[0].x); end
      @(negedge clk);
      d_valid = 1'b0;
      @(posedge clk); #1;
      total++; if (u1.g_ch[0].x !== 10'd0) begin bad++; $display("FAIL latency_k1: got x=%0d want 0", u1.g_ch[0].x); end
      @(posedge clk); #1;
      total++; if (u1_q[0] !== 1'b0) begin bad++; $display("FAIL latency_k2: got q=%b want 0", u1_q[0]); end
      repeat (2) @(negedge clk);
      count_ones(1024);
      total++; if (cs[0] != 512) begin bad++; $display("FAIL dens_s_000: got %0d want 512", cs[0]); end
      total++; if (cs[1] != 0) begin bad++; $display("FAIL dens_s_200: got %0d want 0", cs[1]); end
      total++; if (cu[0] != 0 || cu[1] != 512) begin bad++; $display("FAIL dens_u_0_512: got %0d/%0d want 0/512", cu[0], cu[1]); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      d = {10'h3FF, 10'h111}; d_valid = 1'b1;
      @(negedge clk);
      total++; if (u1.g_ch[0].s !== 10'h111) begin bad++; $display("FAIL b2b_first: got %0h want 111", u1.g_ch[0].s); end
      d = {10'h3FF, 10'h222};
      @(negedge clk);
      total++; if (u1.g_ch[0].s !== 10'h222) begin bad++; $display("FAIL b2b_second: got %0h want 222", u1.g_ch[0].s); end
      d = {10'h3FF, 10'h3FF};
      @(negedge clk);
      d_valid = 1'b0;
      total++; if (u1.g_ch[0].s !== 10'h3FF || u1.g_ch[1].s !== 10'h3FF) begin bad++; $display("FAIL b2b_last: got %0h/%0h want 3ff/3ff", u1.g_ch[0].s, u1.g_ch[1].s); end
      @(negedge clk);
      total++; if (u1.g_ch[0].x !== 10'h3FF) begin bad++; $display("FAIL b2b_x: got %0h want 3ff", u1.g_ch[0].x); end
   endtask

   task automatic test_mute_ramp();
      bit shape_ok;
      shape_ok = 1'b1;
      mute = 1'b1; d = {10'h000, 10'h3FF}; d_valid = 1'b1;
      @(negedge clk);
      d_valid = 1'b0;
      total++; if (u1_st !== ST_DOWN || u1_ramping !== 1'b1) begin bad++; $display("FAIL mute_enter: got state=%0d want %0d", u1_st, ST_DOWN); end
      total++; if (u1.g_ch[1].s !== 10'd0 || u1.g_ch[0].x !== 10'd1023) begin bad++; $display("FAIL mute_with_valid: got s1=%0d x0=%0d want 0/1023", u1.g_ch[1].s, u1.g_ch[0].x); end
      for (int n = 1; n <= 511; n++) begin
         @(negedge clk);
         if (u1.g_ch[0].x !== 10'(1023 - n) || u1.g_ch[1].x !== 10'(1023 - n) || u1_muted !== 1'b0) shape_ok = 1'b0;
      end
      total++; if (!shape_ok) begin bad++; $display("FAIL ramp_down_shape: got 0 want 1"); end
      @(negedge clk);
      total++; if (u1_muted !== 1'b1 || u1_ramping !== 1'b0) begin bad++; $display("FAIL ramp_down_end: got muted=%b ramping=%b want 1/0", u1_muted, u1_ramping); end
   endtask

   task automatic test_reversal();
      int n_play, j_play;
      bit shape_ok;
      n_play = 0; j_play = 0; shape_ok = 1'b1;
      mute = 1'b0;
      for (int n = 0; n <= 600 && n_play == 0; n++) begin
         @(negedge clk);
         if (u1_st == ST_PLAY) n_play = n;
      end
      total++; if (n_play != 513) begin bad++; $display("FAIL rev_unmute_len: got %0d want 513", n_play); end
      mute = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 323; i++) begin
         @(negedge clk);
         if (u1.g_ch[0].x !== 10'(1023 - i) || u1.g_ch[1].x !== 10'(i)) shape_ok = 1'b0;
      end
      mute = 1'b0;
      @(negedge clk);
      total++; if (u1_st !== ST_UP || u1.g_ch[0].x !== 10'd699) begin bad++; $display("FAIL rev_turn: got state=%0d x=%0d want %0d/699", u1_st, u1.g_ch[0].x, ST_UP); end
      for (int j = 325; j <= 800 && j_play == 0; j++) begin
         @(negedge clk);
         if (j <= 648 && (u1.g_ch[0].x !== 10'(j + 375) || u1.g_ch[1].x !== 10'(648 - j))) shape_ok = 1'b0;
         if (u1_st == ST_PLAY) j_play = j;
      end
      total++; if (!shape_ok) begin bad++; $display("FAIL rev_shape: got 0 want 1"); end
      total++; if (j_play != 649 || u1.g_ch[0].x !== 10'd1023) begin bad++; $display("FAIL rev_play: got %0d x=%0d want 649/1023", j_play, u1.g_ch[0].x); end
   endtask

   task automatic test_reset_mid_play();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++; if ({u1_q, s1_q, o2_q} !== 6'b0) begin bad++; $display("FAIL midreset_q: got %b want 000000", {u1_q, s1_q, o2_q}); end
      total++; if ({u1_muted, s1_muted, o2_muted} !== 3'b111 || {u1_ramping, s1_ramping, o2_ramping} !== 3'b000) begin bad++; $display("FAIL midreset_flags: got %b want 111000", {u1_muted, s1_muted, o2_muted, u1_ramping, s1_ramping, o2_ramping}); end
      total++; if (u1.g_ch[0].x !== 10'd512 || u1.g_ch[0].s !== 10'd512) begin bad++; $display("FAIL midreset_x: got %0d/%0d want 512/512", u1.g_ch[0].x, u1.g_ch[0].s); end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      total++; if (u1_st !== ST_UP || o2_st !== ST_UP) begin bad++; $display("FAIL midreset_release: got %0d/%0d want %0d", u1_st, o2_st, ST_UP); end
   endtask

   task automatic test_order2();
      int n_play;
      n_play = 0;
      @(negedge clk);
      d = {10'h200, 10'h0C0}; d_valid = 1'b1;
      @(negedge clk);
      d_valid = 1'b0;
      for (int n = 0; n < 1000 && n_play == 0; n++) begin
         @(negedge clk);
         if (o2_st == ST_PLAY) n_play = n + 1;
      end
      total++; if (n_play == 0) begin bad++; $display("FAIL o2_play: got timeout want PLAY"); end
      repeat (256) @(negedge clk);
      count_ones(4096);
      total++; if (co[0] < 766 || co[0] > 770) begin bad++; $display("FAIL o2_dens_0c0: got %0d want 766..770", co[0]); end
      total++; if (co[1] < 2046 || co[1] > 2050) begin bad++; $display("FAIL o2_dens_200: got %0d want 2046..2050", co[1]); end
      total++; if (cu[0] != 768 || cu[1] != 2048) begin bad++; $display("FAIL o1_dens_4096: got %0d/%0d want 768/2048", cu[0], cu[1]); end
      d = {10'h140, 10'h2C0}; d_valid = 1'b1;
      @(negedge clk);
      d_valid = 1'b0;
      repeat (256) @(negedge clk);
      count_ones(4096);
      total++; if (co[0] < 2814 || co[0] > 2818) begin bad++; $display("FAIL o2_dens_2c0: got %0d want 2814..2818", co[0]); end
      total++; if (co[1] < 1278 || co[1] > 1282) begin bad++; $display("FAIL o2_dens_140: got %0d want 1278..1282", co[1]); end
      total++; if (cu[0] != 2816) begin bad++; $display("FAIL o1_dens_2c0: got %0d want 2816", cu[0]); end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_density_o1();
      test_signed_latency();
      test_back_to_back();
      test_mute_ramp();
      test_reversal();
      test_reset_mid_play();
      test_order2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
